// File: rtl/alu_share_if.sv
// Requester/ALU-side bundle for the shared-ALU arbiter.
// The master is the requesters plus ALU datapath; the slave is the arbiter.
interface alu_share_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] a_in;
  logic [4*WIDTH-1:0] b_in;
  logic [4*OPW-1:0]   op_in;
  logic [WIDTH-1:0]   alu_result;
  logic [3:0]         grant;
  logic [1:0]         sel;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [OPW-1:0]     alu_op;
  logic               alu_start;
  logic [WIDTH-1:0]   result;
  logic [3:0]         done;
  logic               busy;

  modport master (
    output req, a_in, b_in, op_in, alu_result,
    input  grant, sel, alu_a, alu_b, alu_op, alu_start, result, done, busy
  );

  modport slave (
    input  req, a_in, b_in, op_in, alu_result,
    output grant, sel, alu_a, alu_b, alu_op, alu_start, result, done, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU among four requesters: latch operands on grant,
// pulse start, wait ALU_LAT cycles, capture the result and pulse done.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1   // must be >= 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_share_if.slave   bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  logic [1:0]       r_state;
  logic [1:0]       r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_grant;
  logic [1:0]       r_sel;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OPW-1:0]   r_alu_op;
  logic             r_start;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_done;
  logic             r_busy;

  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic [1:0] w_idx;
  logic       w_any;

  // Rotate requests so bit 0 is the pointer slot; lowest set bit wins.
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < 4; k++) w_rot[k] = bus.req[r_ptr + 2'(k)];
  end

  always_comb begin
    w_off = 2'd0;
    for (int k = 3; k >= 0; k--) if (w_rot[k]) w_off = 2'(k);
  end

  assign w_idx = r_ptr + w_off;
  assign w_any = |bus.req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_grant  <= '0;
      r_sel    <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      r_start  <= 1'b0;
      r_result <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_grant  <= 4'b0001 << w_idx;
          r_sel    <= w_idx;
          r_alu_a  <= bus.a_in[w_idx*WIDTH +: WIDTH];
          r_alu_b  <= bus.b_in[w_idx*WIDTH +: WIDTH];
          r_alu_op <= bus.op_in[w_idx*OPW +: OPW];
          r_start  <= 1'b1;
          r_busy   <= 1'b1;
          r_state  <= S_ISSUE;
        end
        S_ISSUE: begin
          r_start <= 1'b0;
          r_cnt   <= CW'(ALU_LAT - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_result <= bus.alu_result;
            r_done   <= r_grant;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          r_done  <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= r_sel + 2'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.sel       = r_sel;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_start = r_start;
  assign bus.result    = r_result;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance at ALU_LAT=1, one at ALU_LAT=3.
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_if #(.WIDTH(32), .OPW(3)) if1 ();
  alu_share_if #(.WIDTH(32), .OPW(3)) if3 ();

  alu_share_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  alu_share_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'd0: alu_f = a & b;
      3'd1: alu_f = a | b;
      3'd2: alu_f = a ^ b;
      3'd4: alu_f = a - b;
      default: alu_f = a + b;
    endcase
  endfunction

  // ALU models: result is only valid exactly ALU_LAT cycles after start.
  logic       s1 = 1'b0;
  logic [2:0] s3 = 3'b000;
  always @(posedge clk) begin
    s1 <= if1.alu_start;
    s3 <= {s3[1:0], if3.alu_start};
  end
  assign if1.alu_result = s1    ? alu_f(if1.alu_a, if1.alu_b, if1.alu_op) : 32'hDEAD_BEEF;
  assign if3.alu_result = s3[2] ? alu_f(if3.alu_a, if3.alu_b, if3.alu_op) : 32'hDEAD_BEEF;

  int total = 0;
  int bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if1.a_in[i*32 +: 32] = a;
    if1.b_in[i*32 +: 32] = b;
    if1.op_in[i*3 +: 3]  = op;
  endtask

  // Called in the IDLE cycle where req is already driven; ends in the next IDLE cycle.
  task automatic op_check(input string tag, input logic [1:0] g, input logic [31:0] ea,
                          input logic [31:0] eb, input logic [2:0] eop, input logic [31:0] eres);
    step();
    chk({tag, ".grant"}, 64'(if1.grant), 64'(4'b0001 << g));
    chk({tag, ".sel"},   64'(if1.sel), 64'(g));
    chk({tag, ".start"}, 64'(if1.alu_start), 64'd1);
    chk({tag, ".busy"},  64'(if1.busy), 64'd1);
    chk({tag, ".alu_a"}, 64'(if1.alu_a), 64'(ea));
    chk({tag, ".alu_b"}, 64'(if1.alu_b), 64'(eb));
    chk({tag, ".alu_op"}, 64'(if1.alu_op), 64'(eop));
    step();
    chk({tag, ".start_off"}, 64'(if1.alu_start), 64'd0);
    chk({tag, ".no_done"}, 64'(if1.done), 64'd0);
    step();
    chk({tag, ".done"},   64'(if1.done), 64'(4'b0001 << g));
    chk({tag, ".result"}, 64'(if1.result), 64'(eres));
    if1.req[g] = 1'b0;
    step();
    chk({tag, ".idle_busy"},  64'(if1.busy), 64'd0);
    chk({tag, ".idle_done"},  64'(if1.done), 64'd0);
    chk({tag, ".idle_grant"}, 64'(if1.grant), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{2'd0, 32'd5,          32'd7,          3'd3, 32'd12};
    vt[1] = '{2'd1, 32'hF0F0_0000,  32'h0FF0_FFFF,  3'd0, 32'h00F0_0000};
    vt[2] = '{2'd2, 32'hFFFF_FFFF,  32'd1,          3'd3, 32'd0};
    vt[3] = '{2'd3, 32'd10,         32'd3,          3'd4, 32'd7};
    vt[4] = '{2'd0, 32'hAAAA_AAAA,  32'h5555_5555,  3'd1, 32'hFFFF_FFFF};
    vt[5] = '{2'd3, 32'h1234_5678,  32'hFFFF_0000,  3'd2, 32'hEDCB_5678};

    if1.req = '0; if1.a_in = '0; if1.b_in = '0; if1.op_in = '0;
    if3.req = '0; if3.a_in = '0; if3.b_in = '0; if3.op_in = '0;

    // Reset state
    rst_n = 1'b0;
    step(); step();
    chk("rst.grant", 64'(if1.grant), 64'd0);
    chk("rst.sel", 64'(if1.sel), 64'd0);
    chk("rst.done", 64'(if1.done), 64'd0);
    chk("rst.busy", 64'(if1.busy), 64'd0);
    chk("rst.start", 64'(if1.alu_start), 64'd0);
    chk("rst.result", 64'(if1.result), 64'd0);
    chk("rst.alu_a", 64'(if1.alu_a), 64'd0);
    chk("rst3.busy", 64'(if3.busy), 64'd0);
    rst_n = 1'b1;

    // All four requesting from reset: order 0,1,2,3,0, done every 4 cycles
    for (int i = 0; i < 4; i++) set_slot(i, 32'(10 * (i + 1)), 32'd1, 3'd3);
    if1.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("rr%0d.grant", n), 64'(if1.grant), 64'(4'b0001 << (n % 4)));
      chk($sformatf("rr%0d.sel", n), 64'(if1.sel), 64'(n % 4));
      chk($sformatf("rr%0d.start", n), 64'(if1.alu_start), 64'd1);
      step();
      step();
      chk($sformatf("rr%0d.done", n), 64'(if1.done), 64'(4'b0001 << (n % 4)));
      chk($sformatf("rr%0d.result", n), 64'(if1.result), 64'(10 * ((n % 4) + 1) + 1));
      if (n == 4) if1.req = 4'b0000;
      step();
      chk($sformatf("rr%0d.gap", n), 64'(if1.done), 64'd0);
    end

    // Fairness: serve 2 (ptr->3), then 0101 picks 0 (wrap), then 2
    set_slot(0, 32'd1, 32'd2, 3'd3);
    set_slot(2, 32'd40, 32'd2, 3'd4);
    if1.req = 4'b0100;
    op_check("fair_a", 2'd2, 32'd40, 32'd2, 3'd4, 32'd38);
    if1.req = 4'b0101;
    op_check("fair_b", 2'd0, 32'd1, 32'd2, 3'd3, 32'd3);
    op_check("fair_c", 2'd2, 32'd40, 32'd2, 3'd4, 32'd38);

    // Table-driven single requests
    for (int i = 0; i < 6; i++) begin
      for (int s = 0; s < 4; s++) set_slot(s, 32'hBAD0_0000 + 32'(s), 32'h0000_0BAD, 3'd7);
      set_slot(int'(vt[i].idx), vt[i].a, vt[i].b, vt[i].op);
      if1.req = 4'b0001 << vt[i].idx;
      op_check($sformatf("vec%0d", i), vt[i].idx, vt[i].a, vt[i].b, vt[i].op, vt[i].res);
    end

    // Operand change and request drop mid-operation
    set_slot(1, 32'd100, 32'd23, 3'd3);
    if1.req = 4'b0010;
    step();
    chk("chg.grant", 64'(if1.grant), 64'b0010);
    set_slot(1, 32'd999, 32'd1, 3'd0);
    if1.req = 4'b0000;
    step();
    chk("chg.alu_a", 64'(if1.alu_a), 64'd100);
    chk("chg.alu_op", 64'(if1.alu_op), 64'd3);
    step();
    chk("chg.done", 64'(if1.done), 64'b0010);
    chk("chg.result", 64'(if1.result), 64'd123);
    step();
    chk("chg.idle", 64'(if1.busy), 64'd0);

    // ALU_LAT=3: capture only in the third WAIT cycle, done at t+5
    if3.a_in[31:0] = 32'd20;
    if3.b_in[31:0] = 32'd22;
    if3.op_in[2:0] = 3'd3;
    if3.req = 4'b0001;
    step();
    chk("lat3.start", 64'(if3.alu_start), 64'd1);
    chk("lat3.sel", 64'(if3.sel), 64'd0);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk($sformatf("lat3.wait%0d.done", c), 64'(if3.done), 64'd0);
      chk($sformatf("lat3.wait%0d.busy", c), 64'(if3.busy), 64'd1);
    end
    chk("lat3.result_early", 64'(if3.result), 64'd0);
    step();
    chk("lat3.done", 64'(if3.done), 64'b0001);
    chk("lat3.result", 64'(if3.result), 64'd42);
    if3.req = 4'b0000;
    step();
    chk("lat3.idle", 64'(if3.busy), 64'd0);
    chk("lat3.hold", 64'(if3.result), 64'd42);

    // Reset during WAIT: no done, outputs cleared, then fresh grant to 3
    set_slot(1, 32'd8, 32'd8, 3'd3);
    set_slot(3, 32'd6, 32'd1, 3'd4);
    if1.req = 4'b0010;
    step();
    chk("mrst.grant", 64'(if1.grant), 64'b0010);
    step();
    rst_n = 1'b0;
    step();
    chk("mrst.done", 64'(if1.done), 64'd0);
    chk("mrst.grant0", 64'(if1.grant), 64'd0);
    chk("mrst.busy", 64'(if1.busy), 64'd0);
    chk("mrst.result", 64'(if1.result), 64'd0);
    chk("mrst.alu_a", 64'(if1.alu_a), 64'd0);
    rst_n = 1'b1;
    if1.req = 4'b1000;
    op_check("post_rst", 2'd3, 32'd6, 32'd1, 3'd4, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit ALU between four requesters using round-robin arbitration.
- Drives the 2-bit operand-mux select (sel[1] is the MSB) for the granted requester and latches that requester's operands and opcode.
- Issues a start pulse to the ALU, waits a fixed ALU latency, then returns the result to the granted requester with a one-cycle done pulse.
- Sits between the requester ports and the ALU datapath, in place of any static select wiring.

Parameters:
- WIDTH, 32, operand/result width in bits.
- OPW, 3, ALU opcode width in bits.
- ALU_LAT, 1, ALU cycles from start to valid alu_result. Must be 1 or more; 0 is illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  4  per-requester request; req[i] is held high until done[i].
- a_in  input  4*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- b_in  input  4*WIDTH  operand B, packed the same way as a_in.
- op_in  input  4*OPW  opcode; requester i occupies bits [i*OPW +: OPW].
- alu_result  input  WIDTH  ALU output.
- grant  output  4  one-hot grant, held from issue through done.
- sel  output  2  binary index of the granted requester (sel[1] MSB, sel[0] LSB).
- alu_a  output  WIDTH  latched operand A.
- alu_b  output  WIDTH  latched operand B.
- alu_op  output  OPW  latched opcode.
- alu_start  output  1  one-cycle ALU start pulse.
- result  output  WIDTH  captured ALU result.
- done  output  4  one-hot, one-cycle completion pulse.
- busy  output  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset (rst_n low at a rising edge):
  - state=IDLE.
  - grant, done, sel, alu_a, alu_b, alu_op, result = 0.
  - alu_start=0, busy=0.
  - RR pointer=0, wait counter=0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req is nonzero, pick the winner g: search indices ptr, ptr+1, ptr+2, ptr+3 (mod 4) and take the first index with req high.
  - At the same edge: grant<=1<<g; sel<=g; latch alu_a, alu_b, alu_op from slot g; alu_start<=1; busy<=1; go to ISSUE.
  - If req is 0, stay in IDLE with all pulses low.
- ISSUE (exactly one cycle):
  - alu_start is high in this cycle.
  - At the edge: alu_start<=0, counter<=ALU_LAT-1, go to WAIT.
- WAIT:
  - Lasts exactly ALU_LAT cycles.
  - When counter==0: result<=alu_result, done<=grant, go to DONE.
  - Otherwise decrement the counter.
- DONE (exactly one cycle):
  - done[g] and result are valid in this cycle.
  - At the edge: done<=0, grant<=0, busy<=0, ptr<=(g+1) mod 4, go to IDLE.
- Latency: a request first seen in IDLE at cycle t gives:
  - grant, sel and alu_start visible at t+1;
  - done at t+2+ALU_LAT.
- Throughput: one operation per ALU_LAT+3 cycles. IDLE always takes one cycle between operations.
- result holds its value until the next capture. done is a pulse only.
- sel, grant, alu_a, alu_b and alu_op stay stable from ISSUE through DONE. Later changes to a_in, b_in or op_in do not affect an operation in progress.
- If req[g] drops mid-operation, the operation still completes and done[g] still pulses.
- Requests that arrive while busy are held off; they are only evaluated in IDLE.
- Simultaneous requests: the requester nearest ptr going upward wins. Losers keep req high and are served in later rounds. No requester waits more than 3 operations.
- Reset mid-operation: abort immediately to the reset values, with no done pulse. ptr returns to 0.
- The pointer wraps from 3 to 0.

Test Plan:
- Single request, ALU_LAT=1: req=0001, a0=5, b0=7, op0=3 →
  - sel=00, grant=0001, alu_start high one cycle at t+1;
  - alu_a=5, alu_b=7, alu_op=3;
  - ALU model returns 12 → done=0001 and result=12 at t+3;
  - busy low at t+4.
- All four requesting, each held: req=1111 from reset → grant order 0,1,2,3,0; sel 00,01,10,11,00; each done spaced 4 cycles apart.
- Round-robin fairness:
  - after serving requester 2, req=0101 → requester 0 wins next (ptr=3 wraps to 0);
  - then requester 2 wins.
- Operand change and request drop mid-operation: after grant to requester 1, change a_in slot 1 and drop req[1] →
  - alu_a keeps its latched value;
  - done[1] still pulses;
  - result reflects the latched operands.
- ALU_LAT=3: alu_result is valid only in the third WAIT cycle → result captured correctly; done at t+5.
- Reset mid-operation: rst_n low during WAIT → next cycle all outputs are 0, no done pulse; a new req=1000 is then granted to requester 3 (sel=11) within 1 cycle of IDLE.
